axi_revision_reader: RTL and testbench

//  AXI4-Lite read-only master that fetches the full build-version record from an axi_revision slave.
//  On a start pulse it issues 12 single reads in fixed order and latches each word into output registers.
//  It then raises results_valid with a per-register error mask.

---
 rtl/axi_revision_pkg.sv | 57 +++++
 rtl/axi_revision_reader.sv | 146 ++++++++++++++
 tb/tb_axi_revision_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_revision_pkg.sv
// Shared definitions for the revision register block: register offsets, AXI
// response codes, the read-sequence FSM states and the index->offset map.
package axi_revision_pkg;

  localparam int NUM_REV_REGS = 12;

  localparam logic [7:0] REG_MAJOR       = 8'h00;
  localparam logic [7:0] REG_MINOR       = 8'h04;
  localparam logic [7:0] REG_BUILD       = 8'h08;
  localparam logic [7:0] REG_RCAND       = 8'h0C;
  localparam logic [7:0] REG_DATE        = 8'h10;
  localparam logic [7:0] REG_RTL_TYPE    = 8'h14;
  localparam logic [7:0] REG_RTL_SUBTYPE = 8'h18;
  localparam logic [7:0] REG_GIT_HASH_0  = 8'h40;
  localparam logic [7:0] REG_GIT_HASH_1  = 8'h44;
  localparam logic [7:0] REG_GIT_HASH_2  = 8'h48;
  localparam logic [7:0] REG_GIT_HASH_3  = 8'h4C;
  localparam logic [7:0] REG_GIT_HASH_4  = 8'h50;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  // Read index -> byte offset; also used by the slave so both agree on layout.
  function automatic logic [7:0] rev_offset(input logic [3:0] idx);
    case (idx)
      4'd0:    rev_offset = REG_MAJOR;
      4'd1:    rev_offset = REG_MINOR;
      4'd2:    rev_offset = REG_BUILD;
      4'd3:    rev_offset = REG_RCAND;
      4'd4:    rev_offset = REG_DATE;
      4'd5:    rev_offset = REG_RTL_TYPE;
      4'd6:    rev_offset = REG_RTL_SUBTYPE;
      4'd7:    rev_offset = REG_GIT_HASH_0;
      4'd8:    rev_offset = REG_GIT_HASH_1;
      4'd9:    rev_offset = REG_GIT_HASH_2;
      4'd10:   rev_offset = REG_GIT_HASH_3;
      4'd11:   rev_offset = REG_GIT_HASH_4;
      default: rev_offset = REG_MAJOR;
    endcase
  endfunction

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != 2'(RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_revision_reader.sv
// AXI4-Lite read-only master: on start, fetches all 12 revision registers in
// fixed order, one outstanding read at a time, and latches them with an error mask.
module axi_revision_reader
  import axi_revision_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int AW        = 7
) (
  input  logic           AXI_ACLK,
  input  logic           AXI_ARESET,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           results_valid,
  output logic [11:0]    error_mask,
  output logic [31:0]    ver_major,
  output logic [31:0]    ver_minor,
  output logic [31:0]    ver_build,
  output logic [31:0]    ver_rcand,
  output logic [31:0]    ver_date,
  output logic [31:0]    rtl_type,
  output logic [31:0]    rtl_subtype,
  output logic [159:0]   git_hash,
  output logic [1:0]     dbg_state_o,
  output logic [AW-1:0]  M_AXI_ARADDR,
  output logic           M_AXI_ARVALID,
  output logic [2:0]     M_AXI_ARPROT,
  input  logic           M_AXI_ARREADY,
  input  logic [31:0]    M_AXI_RDATA,
  input  logic [1:0]     M_AXI_RRESP,
  input  logic           M_AXI_RVALID,
  output logic           M_AXI_RREADY,
  output logic [AW-1:0]  M_AXI_AWADDR,
  output logic           M_AXI_AWVALID,
  output logic [2:0]     M_AXI_AWPROT,
  input  logic           M_AXI_AWREADY,
  output logic [31:0]    M_AXI_WDATA,
  output logic [3:0]     M_AXI_WSTRB,
  output logic           M_AXI_WVALID,
  input  logic           M_AXI_WREADY,
  output logic           M_AXI_BREADY,
  input  logic           M_AXI_BVALID,
  input  logic [1:0]     M_AXI_BRESP
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both
  // high; ARVALID/ARADDR are held until accepted, RREADY is high only in ST_DATA.

  rd_state_e     state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          rv_q, rv_d;
  logic [11:0]   em_q, em_d;
  logic          store_en;
  logic [31:0]   regs_q [NUM_REV_REGS];

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rv_q    <= 1'b0;
      em_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rv_q    <= rv_d;
      em_q    <= em_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rv_d     = rv_q;
    em_d     = em_q;
    store_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rv_d    = 1'b0;
          em_d    = '0;
          idx_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (M_AXI_ARREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (M_AXI_RVALID) begin
          store_en = 1'b1;
          if (resp_is_error(M_AXI_RRESP)) em_d[idx_q] = 1'b1;
          if (idx_q == 4'(NUM_REV_REGS - 1)) begin
            rv_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Error responses still store RDATA; a decode-error slave returns zero.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      for (int k = 0; k < NUM_REV_REGS; k++) regs_q[k] <= '0;
    end else if (store_en) begin
      regs_q[idx_q] <= M_AXI_RDATA;
    end
  end

  assign busy          = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign done          = (state_q == ST_DONE);
  assign results_valid = rv_q;
  assign error_mask    = em_q;
  assign dbg_state_o   = state_q;

  assign ver_major   = regs_q[0];
  assign ver_minor   = regs_q[1];
  assign ver_build   = regs_q[2];
  assign ver_rcand   = regs_q[3];
  assign ver_date    = regs_q[4];
  assign rtl_type    = regs_q[5];
  assign rtl_subtype = regs_q[6];
  assign git_hash    = {regs_q[7], regs_q[8], regs_q[9], regs_q[10], regs_q[11]};

  assign M_AXI_ARADDR  = AW'(BASE_ADDR) + AW'(rev_offset(idx_q));
  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state_q == ST_DATA);

  assign M_AXI_AWADDR  = '0;
  assign M_AXI_AWVALID = 1'b0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = '0;
  assign M_AXI_WSTRB   = '0;
  assign M_AXI_WVALID  = 1'b0;
  assign M_AXI_BREADY  = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP};

endmodule

// File: tb/tb_axi_revision_reader.sv
// Directed bench for axi_revision_reader with a behavioural AXI4-Lite read slave.
module tb_axi_revision_reader;
  import axi_revision_pkg::*;

  localparam int         AW   = 7;
  localparam logic [6:0] BASE = 7'h20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           start;
  logic           busy, done, results_valid;
  logic [11:0]    error_mask;
  logic [31:0]    ver_major, ver_minor, ver_build, ver_rcand, ver_date, rtl_type, rtl_subtype;
  logic [159:0]   git_hash;
  logic [1:0]     dbg_state;
  logic [AW-1:0]  araddr, awaddr;
  logic           arvalid, arready, rvalid, rready, awvalid, wvalid, bready;
  logic [2:0]     arprot, awprot;
  logic [31:0]    rdata, wdata;
  logic [3:0]     wstrb;
  logic [1:0]     rresp;
  logic           awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]     bresp = 2'b00;

  axi_revision_reader #(.BASE_ADDR(32), .AW(AW)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst), .start(start), .busy(busy), .done(done),
    .results_valid(results_valid), .error_mask(error_mask),
    .ver_major(ver_major), .ver_minor(ver_minor), .ver_build(ver_build),
    .ver_rcand(ver_rcand), .ver_date(ver_date), .rtl_type(rtl_type),
    .rtl_subtype(rtl_subtype), .git_hash(git_hash), .dbg_state_o(dbg_state),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARPROT(arprot),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_AWADDR(awaddr),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWPROT(awprot), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BREADY(bready), .M_AXI_BVALID(bvalid),
    .M_AXI_BRESP(bresp)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int ar_cnt = 0;
  logic [AW-1:0] exp_q[$];
  logic [6:0]    off_tbl [12] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h14, 7'h18,
                                  7'h40, 7'h44, 7'h48, 7'h4C, 7'h50};
  logic [31:0]   slv_regs [12];
  logic [11:0]   decerr_mask = '0;
  int            ar_max = 0;
  int            r_max  = 0;
  logic          ar_hold_en = 1'b0;
  logic [6:0]    ar_hold_addr = '0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave model
  task automatic accept_ar(input logic [6:0] a);
    logic [6:0] e;
    arready = 1'b1;
    ar_cnt++;
    check("ar_expected", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("araddr_seq", a, e);
    end
  endtask

  task automatic drive_r(input logic [6:0] a);
    logic [6:0] off;
    logic found;
    off = a - BASE;
    found = 1'b0;
    rdata = '0;
    rresp = RESP_DECERR;
    for (int i = 0; i < 12; i++) begin
      if (off_tbl[i] == off) begin
        found = 1'b1;
        if (decerr_mask[i]) begin
          rdata = '0;
          rresp = RESP_DECERR;
        end else begin
          rdata = slv_regs[i];
          rresp = RESP_OKAY;
        end
      end
    end
    rvalid = 1'b1;
  endtask

  initial begin : slave
    int ph, cnt;
    logic [6:0] hold;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    ph = 0; cnt = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; ph = 0;
      end else begin
        if (ph == 4) begin
          rvalid = 1'b0;
          ph = 0;
        end
        case (ph)
          0: if (arvalid) begin
            hold = araddr;
            if (ar_hold_en && araddr == ar_hold_addr) cnt = 1;
            else cnt = $urandom_range(0, ar_max);
            if (cnt == 0) begin accept_ar(hold); ph = 2; end
            else ph = 1;
          end
          1: begin
            check("arvalid_stable", arvalid, 1'b1);
            check("araddr_stable", araddr, hold);
            if (!(ar_hold_en && hold == ar_hold_addr)) cnt--;
            if (cnt == 0) begin accept_ar(hold); ph = 2; end
          end
          2: begin
            arready = 1'b0;
            check("arvalid_drop", arvalid, 1'b0);
            check("rready_in_data", rready, 1'b1);
            cnt = $urandom_range(0, r_max);
            if (cnt == 0) begin drive_r(hold); ph = 4; end
            else ph = 3;
          end
          3: begin
            cnt--;
            if (cnt == 0) begin drive_r(hold); ph = 4; end
          end
          default: ph = 0;
        endcase
      end
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic start_fetch();
    for (int i = 0; i < 12; i++) exp_q.push_back(BASE + off_tbl[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_results(input logic [11:0] exp_mask);
    logic [31:0] got [12];
    got[0] = ver_major; got[1] = ver_minor; got[2] = ver_build; got[3] = ver_rcand;
    got[4] = ver_date;  got[5] = rtl_type;  got[6] = rtl_subtype;
    got[7] = git_hash[159:128]; got[8] = git_hash[127:96]; got[9] = git_hash[95:64];
    got[10] = git_hash[63:32];  got[11] = git_hash[31:0];
    for (int i = 0; i < 12; i++)
      check($sformatf("field%0d", i), got[i], exp_mask[i] ? 32'h0 : slv_regs[i]);
    check("error_mask", error_mask, exp_mask);
    check("results_valid", results_valid, 1'b1);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin : main
    int n;
    logic seen;
    start = 1'b0;
    slv_regs = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h07040019, 32'h52544C01, 32'h00000003,
                 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h11111111, 32'h22222222, 32'h33333333};
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rv", results_valid, 1'b0);
    check("rst_emask", error_mask, 12'h0);
    check("rst_major", ver_major, 32'h0);
    check("rst_hash", git_hash, 160'h0);
    check("rst_state", dbg_state, 2'd0);
    check("arprot", arprot, 3'b000);
    check("bready", bready, 1'b1);
    check("awvalid", awvalid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait slave, latency
    start_fetch();
    check("t1_busy_after_start", busy, 1'b1);
    wait_done(n);
    check("t1_latency", n, 25);
    check("t1_busy_in_done", busy, 1'b0);
    check_results(12'h000);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);
    check("t1_rv_held", results_valid, 1'b1);

    // 2: random AR/R stalls
    ar_max = 7; r_max = 7;
    start_fetch();
    check("t2_rv_cleared", results_valid, 1'b0);
    wait_done(n);
    check_results(12'h000);
    ar_max = 0; r_max = 0;
    @(negedge clk);

    // 3: DECERR on 0x18 only
    decerr_mask = 12'h040;
    start_fetch();
    wait_done(n);
    check_results(12'h040);
    check("t3_subtype", rtl_subtype, 32'h0);
    decerr_mask = '0;
    @(negedge clk);

    // 4: git hash word placement
    slv_regs[7] = 32'h01234567; slv_regs[8] = 32'h89ABCDEF; slv_regs[9] = 32'h00112233;
    slv_regs[10] = 32'h44556677; slv_regs[11] = 32'hDEADBEEF;
    start_fetch();
    wait_done(n);
    check("t4_hash", git_hash, 160'h0123456789ABCDEF0011223344556677DEADBEEF);
    check("t4_hash_hi", git_hash[159:128], 32'h01234567);
    check("t4_hash_lo", git_hash[31:0], 32'hDEADBEEF);
    check_results(12'h000);
    @(negedge clk);

    // 5: start while busy and in DONE ignored, start right after DONE accepted
    ar_cnt = 0;
    start_fetch();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("t5_one_fetch", ar_cnt, 12);
    for (int i = 0; i < 12; i++) exp_q.push_back(BASE + off_tbl[i]);
    start = 1'b1;
    @(negedge clk);
    check("t5_done_start_ignored", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("t5_idle_start_taken", busy, 1'b1);
    check("t5_rv_cleared", results_valid, 1'b0);
    wait_done(n);
    check("t5_two_fetches", ar_cnt, 24);
    check_results(12'h000);
    @(negedge clk);

    // 6: reset while ARVALID is held at index 5
    ar_hold_en = 1'b1;
    ar_hold_addr = BASE + 7'h14;
    start_fetch();
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (arvalid && araddr == BASE + 7'h14) seen = 1'b1;
    end
    check("t6_idx5_reached", seen, 1'b1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_arvalid", arvalid, 1'b0);
    check("t6_rready", rready, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_rv", results_valid, 1'b0);
    check("t6_major_cleared", ver_major, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    ar_hold_en = 1'b0;
    exp_q.delete();
    ar_cnt = 0;
    @(negedge clk);
    start_fetch();
    wait_done(n);
    check("t6_latency", n, 25);
    check("t6_ar_count", ar_cnt, 12);
    check_results(12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
